// File: rtl/cordic_rotation_scheduler_pkg.sv
// Shared definitions for the CORDIC rotation scheduler:
// mode codes, scheduler FSM states and mode normalisation.
package cordic_rotation_scheduler_pkg;

    localparam logic [1:0] MODE_LINEAR     = 2'b00;
    localparam logic [1:0] MODE_CIRCULAR   = 2'b10;
    localparam logic [1:0] MODE_HYPERBOLIC = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } sched_state_e;

    // Code 01 has no pipeline meaning of its own; it behaves as LINEAR.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        logic [1:0] r;
        unique case (m)
            2'b00, 2'b01: r = MODE_LINEAR;
            2'b10:        r = MODE_CIRCULAR;
            default:      r = MODE_HYPERBOLIC;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cordic_rotation_scheduler_rr_arbiter.sv
// Masked round-robin arbiter: first eligible index after ptr_i.
// Ports: elig_i (eligible vector), ptr_i (last winner), gnt_o (one-hot), idx_o (winner index).
module cordic_rotation_scheduler_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  elig_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    int   j;
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!found && elig_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/cordic_rotation_scheduler.sv
// Shares one CORDIC rotation pipeline among NUM_REQ requesters, grouping work by mode
// and draining the pipeline before each mode change; results come back tagged by id.
// Ports: clock/reset (sync, active-high); req_* requester bus with combinational req_ready;
// cordic_* registered operands/mode to the pipeline, cordic_r* pipeline outputs;
// res_* registered tagged results with a one-cycle res_valid pulse.
module cordic_rotation_scheduler
    import cordic_rotation_scheduler_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int PIPE_LATENCY = 28,
    parameter int MAX_BURST    = 16,
    parameter int ID_W         = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [32*NUM_REQ-1:0] req_x,
    input  logic [32*NUM_REQ-1:0] req_y,
    input  logic [32*NUM_REQ-1:0] req_angle,
    input  logic [2*NUM_REQ-1:0] req_mode,
    output logic [31:0]          cordic_x,
    output logic [31:0]          cordic_y,
    output logic [31:0]          cordic_angle,
    output logic [1:0]           cordic_mode,
    input  logic [31:0]          cordic_rx,
    input  logic [31:0]          cordic_ry,
    input  logic [31:0]          cordic_rangle,
    output logic                 res_valid,
    output logic [ID_W-1:0]      res_id,
    output logic [31:0]          res_x,
    output logic [31:0]          res_y,
    output logic [31:0]          res_angle
);

    localparam int IF_W = $clog2(PIPE_LATENCY + 2);
    localparam int B_W  = $clog2(MAX_BURST + 1);

    sched_state_e      state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [B_W-1:0]    burst_q, burst_d;
    logic [IF_W-1:0]   inflight_q, inflight_d;

    logic              iss_v_q;
    logic [ID_W-1:0]   iss_id_q;
    logic [PIPE_LATENCY-1:0] tag_v_q;
    logic [ID_W-1:0]   tag_id_q [PIPE_LATENCY];

    logic [31:0]       cx_q, cy_q, ca_q;
    logic              res_valid_q;
    logic [ID_W-1:0]   res_id_q;
    logic [31:0]       rx_q, ry_q, ra_q;

    logic [NUM_REQ-1:0] same_v, other_v;
    logic [NUM_REQ-1:0] g_gnt, s_gnt;
    logic [ID_W-1:0]    g_idx, s_idx;
    logic               same_pend, other_pend;
    logic               burst_full, grant_en, grant, capture;

    always_comb begin
        same_v  = '0;
        other_v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) begin
                if (norm_mode(req_mode[2*i +: 2]) == mode_q) begin
                    same_v[i] = 1'b1;
                end else begin
                    other_v[i] = 1'b1;
                end
            end
        end
    end

    assign same_pend  = |same_v;
    assign other_pend = |other_v;
    assign burst_full = (burst_q == B_W'(MAX_BURST));

    // A full burst blocks further grants only while another mode is waiting.
    assign grant_en = !reset && (state_q == ST_RUN)
                      && !(other_pend && burst_full);

    cordic_rotation_scheduler_rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_grant_arb (
        .elig_i (same_v & {NUM_REQ{grant_en}}),
        .ptr_i  (rr_q),
        .gnt_o  (g_gnt),
        .idx_o  (g_idx)
    );

    // Picks the next mode in SWITCH with the same fairness as grants.
    cordic_rotation_scheduler_rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_switch_arb (
        .elig_i (other_v),
        .ptr_i  (rr_q),
        .gnt_o  (s_gnt),
        .idx_o  (s_idx)
    );

    assign req_ready = g_gnt;
    assign grant     = |g_gnt;
    assign capture   = tag_v_q[PIPE_LATENCY-1];

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        rr_d       = rr_q;
        burst_d    = burst_q;
        inflight_d = inflight_q;

        if (grant && !capture) begin
            inflight_d = inflight_q + IF_W'(1);
        end else if (capture && !grant) begin
            inflight_d = inflight_q - IF_W'(1);
        end

        if (grant) begin
            rr_d = g_idx;
            if (!burst_full) begin
                burst_d = burst_q + B_W'(1);
            end
        end

        unique case (state_q)
            ST_RUN: begin
                if (other_pend && (!same_pend || burst_full)) begin
                    state_d = ST_DRAIN;
                end
            end
            // Leaves once the last old-mode result is captured on this edge.
            ST_DRAIN: begin
                if (inflight_d == '0) begin
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                if (|s_gnt) begin
                    mode_d = norm_mode(req_mode[2*s_idx +: 2]);
                end
                burst_d = '0;
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_RUN;
            mode_q      <= MODE_LINEAR;
            rr_q        <= ID_W'(NUM_REQ - 1);
            burst_q     <= '0;
            inflight_q  <= '0;
            iss_v_q     <= 1'b0;
            iss_id_q    <= '0;
            tag_v_q     <= '0;
            for (int k = 0; k < PIPE_LATENCY; k++) begin
                tag_id_q[k] <= '0;
            end
            cx_q        <= '0;
            cy_q        <= '0;
            ca_q        <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            rx_q        <= '0;
            ry_q        <= '0;
            ra_q        <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            rr_q       <= rr_d;
            burst_q    <= burst_d;
            inflight_q <= inflight_d;

            // Issue stage keeps the tag aligned with the registered operands.
            iss_v_q  <= grant;
            iss_id_q <= g_idx;
            tag_v_q  <= {tag_v_q[PIPE_LATENCY-2:0], iss_v_q};
            tag_id_q[0] <= iss_id_q;
            for (int k = 1; k < PIPE_LATENCY; k++) begin
                tag_id_q[k] <= tag_id_q[k-1];
            end

            if (grant) begin
                cx_q <= req_x[32*g_idx +: 32];
                cy_q <= req_y[32*g_idx +: 32];
                ca_q <= req_angle[32*g_idx +: 32];
            end

            res_valid_q <= capture;
            if (capture) begin
                res_id_q <= tag_id_q[PIPE_LATENCY-1];
                rx_q     <= cordic_rx;
                ry_q     <= cordic_ry;
                ra_q     <= cordic_rangle;
            end
        end
    end

    assign cordic_x     = cx_q;
    assign cordic_y     = cy_q;
    assign cordic_angle = ca_q;
    assign cordic_mode  = mode_q;
    assign res_valid    = res_valid_q;
    assign res_id       = res_id_q;
    assign res_x        = rx_q;
    assign res_y        = ry_q;
    assign res_angle    = ra_q;

endmodule

// File: tb/tb_cordic_rotation_scheduler.sv
// Randomised bench for cordic_rotation_scheduler with an emulated CORDIC pipeline
// and a transaction-level scheduling model.
module tb_cordic_rotation_scheduler;

    localparam int N  = 4;
    localparam int L  = 28;
    localparam int MB = 16;
    localparam int IW = 2;
    localparam int NCYC = 2900;

    logic              clock;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [32*N-1:0]   req_x;
    logic [32*N-1:0]   req_y;
    logic [32*N-1:0]   req_angle;
    logic [2*N-1:0]    req_mode;
    logic [31:0]       cordic_x, cordic_y, cordic_angle;
    logic [1:0]        cordic_mode;
    logic [31:0]       cordic_rx, cordic_ry, cordic_rangle;
    logic              res_valid;
    logic [IW-1:0]     res_id;
    logic [31:0]       res_x, res_y, res_angle;

    cordic_rotation_scheduler #(
        .NUM_REQ      (N),
        .PIPE_LATENCY (L),
        .MAX_BURST    (MB),
        .ID_W         (IW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_x         (req_x),
        .req_y         (req_y),
        .req_angle     (req_angle),
        .req_mode      (req_mode),
        .cordic_x      (cordic_x),
        .cordic_y      (cordic_y),
        .cordic_angle  (cordic_angle),
        .cordic_mode   (cordic_mode),
        .cordic_rx     (cordic_rx),
        .cordic_ry     (cordic_ry),
        .cordic_rangle (cordic_rangle),
        .res_valid     (res_valid),
        .res_id        (res_id),
        .res_x         (res_x),
        .res_y         (res_y),
        .res_angle     (res_angle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef enum {M_RUN, M_DRAIN, M_SWITCH} mph_e;
    typedef struct {
        int          due;
        int          id;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] a;
    } exp_t;

    int errors = 0;
    int checks = 0;

    bit          pv [N];
    logic [31:0] px [N];
    logic [31:0] py [N];
    logic [31:0] pa [N];
    logic [1:0]  pm [N];

    logic [31:0] hx [64];
    logic [31:0] hy [64];
    logic [31:0] ha [64];
    logic [1:0]  hm [64];

    exp_t        q [$];
    mph_e        ph;
    logic [1:0]  mmode;
    int          mptr;
    int          mburst;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stand-in pipeline transfer functions; mode enters every output.
    function automatic logic [31:0] fx(input logic [31:0] x, input logic [1:0] m);
        return x ^ {m, 30'h0} ^ 32'h0000_1357;
    endfunction
    function automatic logic [31:0] fy(input logic [31:0] x, input logic [31:0] y);
        return y - x;
    endfunction
    function automatic logic [31:0] fa(input logic [31:0] a, input logic [1:0] m);
        return a + 32'h11 + {30'h0, m};
    endfunction

    function automatic logic [1:0] nm(input logic [1:0] m);
        return (m == 2'b01) ? 2'b00 : m;
    endfunction

    function automatic int phase_of(input int cyc);
        if (cyc < 1000) return 0;
        if (cyc < 1600) return 1;
        if (cyc < 2600) return 2;
        return 3;
    endfunction

    function automatic int new_prob(input int phase, input int i);
        case (phase)
            0:       return 25;
            1:       return (i < 2) ? 100 : 0;
            2:       return 50;
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] pick_mode(input int phase, input int i);
        logic [1:0] r;
        r = 2'($urandom_range(3));
        if (phase == 1) r = (i == 0) ? 2'b00 : 2'b10;
        if (phase == 2 && (i % 2 == 0)) r = {1'b0, 1'($urandom_range(1))};
        return r;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = pv[i];
            req_x[32*i +: 32]     = px[i];
            req_y[32*i +: 32]     = py[i];
            req_angle[32*i +: 32] = pa[i];
            req_mode[2*i +: 2]    = pm[i];
        end
    endtask

    task automatic model_reset();
        ph     = M_RUN;
        mmode  = 2'b00;
        mptr   = N - 1;
        mburst = 0;
        q.delete();
    endtask

    initial begin
        bit   same [N];
        bit   other [N];
        bit   any_same, any_other, full, busy, found;
        int   gid, j, phase;
        logic [N-1:0] expready;
        exp_t e;

        reset = 1'b1;
        cordic_rx = '0;
        cordic_ry = '0;
        cordic_rangle = '0;
        for (int i = 0; i < 64; i++) begin
            hx[i] = '0; hy[i] = '0; ha[i] = '0; hm[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            pv[i] = 1'b0; px[i] = 32'h1000_0000 + i;
            py[i] = '0; pa[i] = 32'h1000_0000; pm[i] = 2'b00;
        end
        drive();
        req_valid = '1;
        repeat (3) @(negedge clock);
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_mode", 32'(cordic_mode), 32'h0);
        check("rst_cx", cordic_x, 32'h0);
        check("rst_cy", cordic_y, 32'h0);
        check("rst_ca", cordic_angle, 32'h0);
        check("rst_rv", 32'(res_valid), 32'h0);
        check("rst_rid", 32'(res_id), 32'h0);
        check("rst_rx", res_x, 32'h0);
        model_reset();

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clock);
            reset = (cyc == 700 || cyc == 2200);
            phase = phase_of(cyc);

            hx[cyc % 64] = cordic_x;
            hy[cyc % 64] = cordic_y;
            ha[cyc % 64] = cordic_angle;
            hm[cyc % 64] = cordic_mode;
            if (cyc >= L) begin
                j = (cyc - L) % 64;
                cordic_rx     = fx(hx[j], hm[j]);
                cordic_ry     = fy(hx[j], hy[j]);
                cordic_rangle = fa(ha[j], hm[j]);
            end

            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(99) < new_prob(phase, i)) begin
                    pv[i] = 1'b1;
                    px[i] = $urandom;
                    py[i] = $urandom;
                    pa[i] = $urandom;
                    pm[i] = pick_mode(phase, i);
                end
            end
            drive();
            #1;

            any_same  = 1'b0;
            any_other = 1'b0;
            for (int i = 0; i < N; i++) begin
                same[i]  = pv[i] && (nm(pm[i]) == mmode);
                other[i] = pv[i] && (nm(pm[i]) != mmode);
                any_same  |= same[i];
                any_other |= other[i];
            end
            full = (mburst == MB);
            gid  = -1;
            if (!reset && ph == M_RUN && !(any_other && full)) begin
                for (int k = 1; k <= N; k++) begin
                    j = (mptr + k) % N;
                    if (gid < 0 && same[j]) gid = j;
                end
            end
            expready = '0;
            if (gid >= 0) expready[gid] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(expready));
            check("cordic_mode", 32'(cordic_mode), 32'(mmode));

            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                check("res_valid", 32'(res_valid), 32'h1);
                check("res_id", 32'(res_id), 32'(e.id));
                check("res_x", res_x, e.x);
                check("res_y", res_y, e.y);
                check("res_angle", res_angle, e.a);
            end else begin
                check("res_valid_idle", 32'(res_valid), 32'h0);
            end

            if (reset) begin
                model_reset();
            end else begin
                case (ph)
                    M_RUN: begin
                        if (gid >= 0) begin
                            e.due = cyc + L + 2;
                            e.id  = gid;
                            e.x   = fx(px[gid], mmode);
                            e.y   = fy(px[gid], py[gid]);
                            e.a   = fa(pa[gid], mmode);
                            q.push_back(e);
                            pv[gid] = 1'b0;
                            mptr = gid;
                            if (mburst < MB) mburst++;
                        end
                        if (any_other && (!any_same || full)) ph = M_DRAIN;
                    end
                    M_DRAIN: begin
                        busy = 1'b0;
                        foreach (q[k]) if (q[k].due > cyc + 1) busy = 1'b1;
                        if (!busy) ph = M_SWITCH;
                    end
                    default: begin
                        found = 1'b0;
                        for (int k = 1; k <= N; k++) begin
                            j = (mptr + k) % N;
                            if (!found && other[j]) begin
                                found = 1'b1;
                                mmode = nm(pm[j]);
                            end
                        end
                        mburst = 0;
                        ph = M_RUN;
                    end
                endcase
            end
        end

        check("outstanding", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cordic_rotation_scheduler.md
Name: cordic_rotation_scheduler

Overview:
Shares one CORDIC_Rotation pipeline between NUM_REQ requesters, issuing at most one operation per cycle. The pipeline's mode input is not pipelined, and its output scaler also depends on mode, so a single mode is global to all in-flight work. The scheduler groups requests by mode, drains the pipeline before every mode change, and returns each result tagged with its requester id. It sits between the requester bus and the CORDIC_Rotation instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
PIPE_LATENCY, 28, cycles from cordic_* input register to valid rotated outputs
MAX_BURST, 16, max consecutive same-mode issues while another mode is pending
ID_W, 2, requester id width, equal to clog2(NUM_REQ)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester grant (combinational, one-hot or zero)
req_x  in  32*NUM_REQ  packed signed x operands
req_y  in  32*NUM_REQ  packed signed y operands
req_angle  in  32*NUM_REQ  packed angle operands
req_mode  in  2*NUM_REQ  packed modes: 00 LINEAR, 10 CIRCULAR, 11 HYPERBOLIC
cordic_x / cordic_y / cordic_angle  out  32 each  registered operands to the pipeline
cordic_mode  out  2  registered global mode to the pipeline
cordic_rx / cordic_ry / cordic_rangle  in  32 each  pipeline outputs (rotated_x, rotated_y, final_angle)
res_valid  out  1  one-cycle result pulse, no backpressure
res_id  out  ID_W  requester id of the result
res_x / res_y / res_angle  out  32 each  registered results

Behaviour:
- Reset (clock edge with reset=1): state RUN, cordic_mode=00, rr pointer=NUM_REQ-1, burst=0, inflight=0, tag shift register cleared. All res_* and cordic_* outputs are 0. req_ready is 0 during reset. Reset mid-operation discards all in-flight work; no res_valid follows.
- Mode normalisation: 01 is treated as 00 everywhere.
- Request rule: a requester holds req_valid and its operands stable until granted. The handshake is req_valid[i] & req_ready[i].
- Grant: only in RUN. Round-robin among requesters with req_valid=1 and a normalised mode equal to cordic_mode. Search starts at rr pointer+1; the pointer moves to the granted index.
- Issue timing: a grant in cycle t registers the operands onto cordic_* for cycle t+1. A tag {valid, id} enters a PIPE_LATENCY-deep shift register. At the edge where the tag exits, cordic_r* is captured into res_*, so res_valid is high in cycle t+PIPE_LATENCY+2. Throughput is one issue per cycle. Results return in issue order.
- inflight counter: increments on grant and decrements on result capture. When both happen in the same cycle, the count is unchanged. The counter is (clog2(PIPE_LATENCY+2)) bits wide.
- FSM states:
  - RUN → DRAIN: another-mode request is pending, and either no same-mode request is pending or burst==MAX_BURST.
  - DRAIN: no grants. When inflight==0, go to SWITCH. The last result of the old mode is captured while cordic_mode is still old.
  - SWITCH: one cycle, no grants. Load cordic_mode with the mode of the first pending other-mode requester, found by searching from rr pointer+1. Set burst=0, then go to RUN.
- burst: increments on each grant and saturates at MAX_BURST. It resets only in SWITCH. With no other-mode request pending, saturation has no effect.
- No requests pending: remain in RUN with cordic_mode unchanged. A new-mode request arriving while idle takes the path DRAIN, then SWITCH; DRAIN exits at once when inflight==0.

Decomposition:
- Shared package/include (mode codes already in CONSTANTS.v): LINEAR/CIRCULAR/HYPERBOLIC; FSM encodings RUN/DRAIN/SWITCH.
- One natural sub-module, rr_arbiter: NUM_REQ-wide masked round-robin, inputs eligible vector and pointer, output one-hot grant plus index.
- The tag delay line stays inline.

Test Plan:
- Single request: req0 CIRCULAR, x=0x1000_0000, y=0, angle=0x1000_0000, in cycle 5 → cordic_x valid cycle 6, res_valid only in cycle 35, res_id=0, res_* = cordic_r* sampled at cycle 34.
- Round-robin: req0..3 all LINEAR, continuously valid → grants 0,1,2,3,0,... one per cycle; results in the same order, back-to-back.
- Mode drain: req0 CIRCULAR granted cycle 5, req1 HYPERBOLIC valid from cycle 6 → DRAIN until result capture at the edge ending cycle 34; res_valid cycle 35; SWITCH in cycle 35, cordic_mode=11 from cycle 36; req1 granted cycle 36.
- Burst limit: req0 LINEAR continuously valid, req1 CIRCULAR valid → exactly 16 req0 grants, then drain, then req1 granted; burst cleared.
- Mode 01: req2 mode=01 while cordic_mode=00 → granted with no DRAIN or SWITCH.
- Reset mid-flight: 5 grants, then reset 1 cycle → no res_valid for 40 cycles; inflight=0; next grant proceeds normally.
